// File: rtl/serial_word_fifo.sv
// Serial-to-parallel word capture feeding a FIFO. All state lives in the clk
// domain; ser_clk, ser_data and rd_strobe are synchronised and edge-detected here.
module serial_word_fifo #(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int IRQ_THRESH  = 1,
    parameter int MSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_clk,
    input  logic              ser_data,
    input  logic              enable,
    input  logic              rd_strobe,
    input  logic              clr_flags,
    output logic [WORD_W-1:0] data,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              irq,
    output logic              overflow,
    output logic              underflow
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   THRESH   = (ADDR_W + 1)'(IRQ_THRESH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdat_sync_q, rd_sync_q;
    logic                   sclk_prev_q, rd_prev_q;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [WORD_W-1:0] data_q;
    logic              irq_q, irq_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;

    logic [WORD_W-1:0] mem [2**ADDR_W];

    logic bit_evt, rd_evt, sdat;
    logic word_done, wr_ok, pop_ok;

    // Data rides a chain as deep as the clock chain so each bit stays aligned with its edge.
    assign bit_evt = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign rd_evt  = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q;
    assign sdat    = sdat_sync_q[SYNC_STAGES-1];

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_done   = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;

        if (!enable) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (bit_evt) begin
            if (MSB_FIRST != 0) shift_d = {shift_q[WORD_W-2:0], sdat};
            else                shift_d = {sdat, shift_q[WORD_W-1:1]};
            if (cnt_q == LAST_BIT) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A pop on a full FIFO frees the slot the completing word needs.
        pop_ok = rd_evt & ~empty;
        wr_ok  = word_done & (~full | pop_ok);

        if (wr_ok)  wptr_d = wptr_q + ADDR_W'(1);
        if (pop_ok) rptr_d = rptr_q + ADDR_W'(1);

        case ({wr_ok, pop_ok})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        irq_d       = (level_d >= THRESH);
        overflow_d  = (overflow_q & ~clr_flags) | (word_done & ~wr_ok);
        underflow_d = (underflow_q & ~clr_flags) | (rd_evt & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            rd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            rd_prev_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            data_q      <= '0;
            irq_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_clk};
            sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], rd_strobe};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            rd_prev_q   <= rd_sync_q[SYNC_STAGES-1];
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            irq_q       <= irq_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (pop_ok) data_q <= mem[rptr_q];
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by pointers and level.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= shift_d;
    end

    assign data      = data_q;
    assign level     = level_q;
    assign irq       = irq_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_serial_word_fifo.sv
// Directed bench for serial_word_fifo using three parameterisations that share
// the stimulus pins: default, 8-bit MSB-first 4-deep, and 16-bit threshold-3.
module tb_serial_word_fifo;

    logic clk = 1'b0;
    logic rst, ser_clk, ser_data, enable, rd_strobe, clr_flags;

    logic [15:0] data_a;  logic [6:0] level_a;
    logic empty_a, full_a, irq_a, ovf_a, udf_a;
    logic [7:0]  data_b;  logic [2:0] level_b;
    logic empty_b, full_b, irq_b, ovf_b, udf_b;
    logic [15:0] data_c;  logic [3:0] level_c;
    logic empty_c, full_c, irq_c, ovf_c, udf_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_word_fifo dut_a (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .enable(enable),
        .rd_strobe(rd_strobe), .clr_flags(clr_flags), .data(data_a), .level(level_a),
        .empty(empty_a), .full(full_a), .irq(irq_a), .overflow(ovf_a), .underflow(udf_a)
    );

    serial_word_fifo #(.WORD_W(8), .ADDR_W(2), .IRQ_THRESH(3), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .enable(enable),
        .rd_strobe(rd_strobe), .clr_flags(clr_flags), .data(data_b), .level(level_b),
        .empty(empty_b), .full(full_b), .irq(irq_b), .overflow(ovf_b), .underflow(udf_b)
    );

    serial_word_fifo #(.WORD_W(16), .ADDR_W(3), .IRQ_THRESH(3), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .enable(enable),
        .rd_strobe(rd_strobe), .clr_flags(clr_flags), .data(data_c), .level(level_c),
        .empty(empty_c), .full(full_c), .irq(irq_c), .overflow(ovf_c), .underflow(udf_c)
    );

    task automatic do_reset();
        ser_clk = 1'b0; ser_data = 1'b0; rd_strobe = 1'b0; clr_flags = 1'b0; enable = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Each phase lasts 4 clk periods, above the 3-period minimum for two sync stages.
    task automatic send_bit(input logic b);
        ser_data = b;
        ser_clk  = 1'b0;
        repeat (4) @(negedge clk);
        ser_clk  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // bits[0] goes out first.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    // Sends the most significant bit of the w-bit value first.
    task automatic send_msb(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pop();
        rd_strobe = 1'b1;
        repeat (4) @(negedge clk);
        rd_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Final bit of a word whose rising edge coincides with a rd_strobe rising edge.
    task automatic last_bit_with_pop(input logic b);
        ser_data = b;
        ser_clk  = 1'b0;
        repeat (4) @(negedge clk);
        ser_clk   = 1'b1;
        rd_strobe = 1'b1;
        repeat (4) @(negedge clk);
        rd_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (level_a !== 7'd0 || empty_a !== 1'b1 || irq_a !== 1'b0 || data_a !== 16'h0) begin
            bad++; $display("FAIL reset_init: level=%0d empty=%b irq=%b data=%h want 0 1 0 0000", level_a, empty_a, irq_a, data_a); end
        send_bits(32'h1234, 16);
        pop();
        total++; if (data_a !== 16'h1234) begin bad++; $display("FAIL pre_reset_pop: got %h want 1234", data_a); end
        pop();
        total++; if (udf_a !== 1'b1) begin bad++; $display("FAIL pre_reset_udf: got %b want 1", udf_a); end
        send_bits(32'h5555, 16);
        total++; if (level_a !== 7'd1 || irq_a !== 1'b1) begin
            bad++; $display("FAIL pre_reset_level: level=%0d irq=%b want 1 1", level_a, irq_a); end
        send_bits(32'h3F, 6);
        ser_data = 1'b1; ser_clk = 1'b0;
        repeat (4) @(negedge clk);
        ser_clk = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (data_a !== 16'h0 || level_a !== 7'd0 || empty_a !== 1'b1 || full_a !== 1'b0 ||
                     irq_a !== 1'b0 || ovf_a !== 1'b0 || udf_a !== 1'b0) begin
            bad++; $display("FAIL reset_mid_word: data=%h level=%0d empty=%b full=%b irq=%b ovf=%b udf=%b want 0000 0 1 0 0 0 0",
                            data_a, level_a, empty_a, full_a, irq_a, ovf_a, udf_a); end
        ser_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lsb_word();
        send_bits(32'hA5C3, 16);
        total++; if (level_a !== 7'd1 || irq_a !== 1'b1 || empty_a !== 1'b0) begin
            bad++; $display("FAIL lsb_level1: level=%0d irq=%b empty=%b want 1 1 0", level_a, irq_a, empty_a); end
        pop();
        total++; if (data_a !== 16'hA5C3) begin bad++; $display("FAIL lsb_data: got %h want a5c3", data_a); end
        total++; if (level_a !== 7'd0 || irq_a !== 1'b0 || empty_a !== 1'b1) begin
            bad++; $display("FAIL lsb_level0: level=%0d irq=%b empty=%b want 0 0 1", level_a, irq_a, empty_a); end
    endtask

    task automatic test_msb_first();
        do_reset();
        send_bits(32'h4D, 8);  // 1,0,1,1,0,0,1,0 in transmission order
        total++; if (level_b !== 3'd1) begin bad++; $display("FAIL msb_level: got %0d want 1", level_b); end
        pop();
        total++; if (data_b !== 8'hB2) begin bad++; $display("FAIL msb_data: got %h want b2", data_b); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_words [4];
        exp_words[0] = 8'd1; exp_words[1] = 8'd2; exp_words[2] = 8'd3; exp_words[3] = 8'd4;
        do_reset();
        for (int w = 1; w <= 5; w++) send_msb(w, 8);
        total++; if (full_b !== 1'b1 || level_b !== 3'd4 || ovf_b !== 1'b1) begin
            bad++; $display("FAIL fill_state: full=%b level=%0d ovf=%b want 1 4 1", full_b, level_b, ovf_b); end
        for (int i = 0; i < 4; i++) begin
            pop();
            total++; if (data_b !== exp_words[i]) begin
                bad++; $display("FAIL fill_pop%0d: got %h want %h", i, data_b, exp_words[i]); end
        end
        total++; if (udf_b !== 1'b0 || empty_b !== 1'b1) begin
            bad++; $display("FAIL fill_drained: udf=%b empty=%b want 0 1", udf_b, empty_b); end
        pop();
        total++; if (udf_b !== 1'b1 || data_b !== 8'd4) begin
            bad++; $display("FAIL fill_underflow: udf=%b data=%h want 1 04", udf_b, data_b); end
    endtask

    task automatic test_simultaneous_full();
        do_reset();
        for (int w = 1; w <= 4; w++) send_msb(w, 8);
        total++; if (full_b !== 1'b1 || ovf_b !== 1'b0) begin
            bad++; $display("FAIL simfull_pre: full=%b ovf=%b want 1 0", full_b, ovf_b); end
        send_msb(8'h06 >> 1, 7);
        last_bit_with_pop(1'b0);
        total++; if (data_b !== 8'd1 || level_b !== 3'd4 || ovf_b !== 1'b0) begin
            bad++; $display("FAIL simfull: data=%h level=%0d ovf=%b want 01 4 0", data_b, level_b, ovf_b); end
        repeat (4) pop();
        total++; if (data_b !== 8'd6 || empty_b !== 1'b1) begin
            bad++; $display("FAIL simfull_tail: data=%h empty=%b want 06 1", data_b, empty_b); end
    endtask

    task automatic test_simultaneous_empty();
        do_reset();
        send_msb(8'h11, 8);
        pop();
        total++; if (data_b !== 8'h11 || udf_b !== 1'b0) begin
            bad++; $display("FAIL simempty_pre: data=%h udf=%b want 11 0", data_b, udf_b); end
        send_msb(8'h22 >> 1, 7);
        last_bit_with_pop(1'b0);
        total++; if (level_b !== 3'd1 || udf_b !== 1'b1 || data_b !== 8'h11) begin
            bad++; $display("FAIL simempty: level=%0d udf=%b data=%h want 1 1 11", level_b, udf_b, data_b); end
        pop();
        total++; if (data_b !== 8'h22) begin bad++; $display("FAIL simempty_follow: got %h want 22", data_b); end
    endtask

    task automatic test_enable_threshold();
        do_reset();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (level_c !== 4'd0) begin bad++; $display("FAIL en_gated_level: got %0d want 0", level_c); end
        send_bits(32'h0001, 16);
        send_bits(32'h0002, 16);
        total++; if (level_c !== 4'd2 || irq_c !== 1'b0) begin
            bad++; $display("FAIL thresh_below: level=%0d irq=%b want 2 0", level_c, irq_c); end
        send_bits(32'h0003, 16);
        total++; if (level_c !== 4'd3 || irq_c !== 1'b1) begin
            bad++; $display("FAIL thresh_at: level=%0d irq=%b want 3 1", level_c, irq_c); end
        pop();
        total++; if (data_c !== 16'h0001 || irq_c !== 1'b0) begin
            bad++; $display("FAIL en_first_word: data=%h irq=%b want 0001 0", data_c, irq_c); end
        pop(); pop(); pop();
        total++; if (udf_c !== 1'b1 || data_c !== 16'h0003) begin
            bad++; $display("FAIL en_drain: udf=%b data=%h want 1 0003", udf_c, data_c); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
        total++; if (udf_c !== 1'b0 || ovf_c !== 1'b0) begin
            bad++; $display("FAIL clr_flags: udf=%b ovf=%b want 0 0", udf_c, ovf_c); end
    endtask

    initial begin
        test_reset();
        test_lsb_word();
        test_msb_first();
        test_fill_overflow();
        test_simultaneous_full();
        test_simultaneous_empty();
        test_enable_threshold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
